// File: rtl/game_controller.sv
// Match sequencer for the score datapath: gates operator score buttons into
// one/two/three pulses, runs the period/break clock with pause, counts periods.
module game_controller #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int PERIOD_SEC  = 600,
  parameter int BREAK_SEC   = 60,
  parameter int NUM_PERIODS = 4,
  parameter int BUZZ_CYC    = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       pt1,
  input  logic       pt2,
  input  logic       pt3,
  input  logic       team_sel,
  output logic       one,
  output logic       two,
  output logic       three,
  output logic       team,
  output logic [2:0] period,
  output logic [9:0] secs,
  output logic [2:0] state,
  output logic       buzzer
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BUZZ_CYC + 1);

  localparam logic [PW-1:0] TICK_MAX   = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BUZZ_LOAD  = BW'(BUZZ_CYC);
  localparam logic [9:0]    PERIOD_LEN = 10'(PERIOD_SEC);
  localparam logic [9:0]    BREAK_LEN  = 10'(BREAK_SEC);
  localparam logic [2:0]    LAST_PER   = 3'(NUM_PERIODS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUNNING = 3'd1,
    S_PAUSED  = 3'd2,
    S_BREAK   = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  state_t        cur_st, nxt_st;
  logic          start_prev, pause_prev;
  logic [2:0]    pt_prev;
  logic [PW-1:0] presc;
  logic [BW-1:0] buzz_cnt;

  logic       start_rise, pause_rise;
  logic [2:0] pt_rise;
  logic       live, counting, tick, expiry, presc_clr, buzz_load;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    nxt_st     = cur_st;
    start_rise = start & ~start_prev;
    pause_rise = pause & ~pause_prev;
    pt_rise    = {pt3, pt2, pt1} & ~pt_prev;
    live       = (cur_st == S_RUNNING) || (cur_st == S_PAUSED);
    counting   = (cur_st == S_RUNNING) || (cur_st == S_BREAK);
    tick       = counting && (presc == TICK_MAX);
    expiry     = tick && (secs == 10'd1);

    case (cur_st)
      S_IDLE:    if (start_rise) nxt_st = S_RUNNING;
      S_RUNNING: begin
        // Expiry outranks a simultaneous pause; a plain tick still lets pause through.
        if (expiry)          nxt_st = (period == LAST_PER) ? S_OVER : S_BREAK;
        else if (pause_rise) nxt_st = S_PAUSED;
      end
      S_PAUSED:  if (pause_rise) nxt_st = S_RUNNING;
      S_BREAK:   if (expiry) nxt_st = S_IDLE;
      S_OVER:    nxt_st = S_OVER;
      default:   nxt_st = S_IDLE;
    endcase

    // Pause and resume keep the partial second; every other entry restarts it.
    presc_clr = (nxt_st != cur_st) && (nxt_st != S_PAUSED) && (cur_st != S_PAUSED);
    buzz_load = (nxt_st != cur_st) && ((nxt_st == S_BREAK) || (nxt_st == S_OVER));
  end

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_st     <= S_IDLE;
      period     <= 3'd1;
      secs       <= PERIOD_LEN;
      start_prev <= 1'b0;
      pause_prev <= 1'b0;
      pt_prev    <= 3'b000;
      presc      <= '0;
      buzz_cnt   <= '0;
      one        <= 1'b0;
      two        <= 1'b0;
      three      <= 1'b0;
      team       <= 1'b0;
    end else begin
      cur_st     <= nxt_st;
      start_prev <= start;
      pause_prev <= pause;
      pt_prev    <= {pt3, pt2, pt1};

      one   <= live & pt_rise[0];
      two   <= live & pt_rise[1] & ~pt_rise[0];
      three <= live & pt_rise[2] & ~(|pt_rise[1:0]);
      if (live && (|pt_rise)) team <= team_sel;

      if (presc_clr || tick) presc <= '0;
      else if (counting)     presc <= presc + PW'(1);

      // The break length is loaded one cycle after expiry so secs==0 is seen once.
      if (cur_st == S_BREAK && expiry) begin
        period <= period + 3'd1;
        secs   <= PERIOD_LEN;
      end else if (cur_st == S_BREAK && secs == 10'd0) begin
        secs <= BREAK_LEN;
      end else if (tick) begin
        secs <= secs - 10'd1;
      end

      if (buzz_load)              buzz_cnt <= BUZZ_LOAD;
      else if (buzz_cnt != '0)    buzz_cnt <= buzz_cnt - BW'(1);
    end
  end

  assign buzzer = (buzz_cnt != '0);
  assign state  = cur_st;

endmodule
